// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one outstanding request at a time to instruction memory,
// buffers responses in a small queue and presents them to decode with the matching PC+4.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        inst_valid
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = $clog2(QDEPTH) + 1;
    localparam logic [CntW-1:0] QFull = CntW'(QDEPTH);

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       req_addr_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [31:0]       q_pc    [QDEPTH];
    logic [31:0]       q_instr [QDEPTH];

    logic stall, pending, push, pop;

    assign stall   = hazard_detected | freeze;
    assign pending = imem_req & ~imem_ack;
    // A response that arrives with a branch, or while dropping, never enters the queue.
    assign push    = imem_req & imem_ack & ~br_taken & (state_q != StDrop);
    assign pop     = ~br_taken & ~stall & (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (br_taken) begin
            state_d = pending ? StDrop : StReq;
        end else begin
            case (state_q)
                StReq:   if (pending) state_d = StWait;
                StWait:  if (imem_ack) state_d = StReq;
                StDrop:  if (imem_ack) state_d = StReq;
                default: state_d = StReq;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc_q;
        case (state_q)
            StReq:   imem_req = (count_q < QFull);
            StWait,
            StDrop: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
            end
            default: imem_req = 1'b0;
        endcase
        // Reset drops any in-flight request without waiting for an edge.
        if (rst) imem_req = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= PC_RESET;
            req_addr_q  <= PC_RESET;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            Instruction <= 32'h0;
            PC          <= 32'h0;
            inst_valid  <= 1'b0;
        end else begin
            if (state_q == StReq) req_addr_q <= fetch_pc_q;
            if (br_taken) begin
                fetch_pc_q  <= br_addr;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                Instruction <= 32'h0;
                PC          <= 32'h0;
                inst_valid  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + PtrW'(1);
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
                count_q <= count_q + CntW'(push) - CntW'(pop);
                if (!stall) begin
                    if (count_q != '0) begin
                        Instruction <= q_instr[rd_ptr_q];
                        PC          <= q_pc[rd_ptr_q] + 32'd4;
                        inst_valid  <= 1'b1;
                    end else begin
                        Instruction <= 32'h0;
                        inst_valid  <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= imem_addr;
            q_instr[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, stall backpressure, branch redirects and
// asynchronous reset in the middle of a pending request.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_detected, freeze, br_taken;
    logic [31:0] br_addr;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] Instruction, PC;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .PC_RESET (32'h0),
        .QDEPTH   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .freeze          (freeze),
        .br_taken        (br_taken),
        .br_addr         (br_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .Instruction     (Instruction),
        .PC              (PC),
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory answers in the same cycle with data derived from the address.
    task automatic mem_auto();
        imem_ack   = imem_req;
        imem_rdata = imem_addr ^ 32'hA5A5_0000;
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic valid);
        check_eq({tag, "_instr"}, Instruction, instr);
        check_eq({tag, "_pc"}, PC, pc);
        check_eq({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, valid});
    endtask

    initial begin
        rst = 1'b1;
        hazard_detected = 1'b0;
        freeze = 1'b0;
        br_taken = 1'b0;
        br_addr = 32'h0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        #2;
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_out("rst", 32'h0, 32'h0, 1'b0);

        // Streaming fetch, ack every cycle.
        tick();
        rst = 1'b0;
        #1;
        check_eq("c0_req", {31'b0, imem_req}, 32'h1);
        check_eq("c0_addr", imem_addr, 32'h0);
        mem_auto();
        tick();
        check_eq("c1_addr", imem_addr, 32'h4);
        check_eq("c1_valid", {31'b0, inst_valid}, 32'h0);
        mem_auto();
        tick();
        check_out("c2", 32'hA5A5_0000, 32'h4, 1'b1);
        mem_auto();
        tick();
        check_out("c3", 32'hA5A5_0004, 32'h8, 1'b1);
        mem_auto();
        tick();
        check_out("c4", 32'hA5A5_0008, 32'hC, 1'b1);
        mem_auto();
        hazard_detected = 1'b1;

        // Stall for three cycles: queue fills, request stops.
        tick();
        check_eq("c5_req", {31'b0, imem_req}, 32'h0);
        check_out("c5", 32'hA5A5_0008, 32'hC, 1'b1);
        mem_auto();
        tick();
        check_eq("c6_req", {31'b0, imem_req}, 32'h0);
        check_out("c6", 32'hA5A5_0008, 32'hC, 1'b1);
        mem_auto();
        tick();
        hazard_detected = 1'b0;
        check_out("c7", 32'hA5A5_0008, 32'hC, 1'b1);
        mem_auto();
        tick();
        check_out("c8", 32'hA5A5_000C, 32'h10, 1'b1);
        check_eq("c8_req", {31'b0, imem_req}, 32'h1);
        check_eq("c8_addr", imem_addr, 32'h14);
        mem_auto();
        tick();
        check_out("c9", 32'hA5A5_0010, 32'h14, 1'b1);
        mem_auto();
        tick();
        check_out("c10", 32'hA5A5_0014, 32'h18, 1'b1);
        mem_auto();
        br_taken = 1'b1;
        br_addr  = 32'h40;

        // Branch with no pending request.
        tick();
        br_taken = 1'b0;
        check_out("c11", 32'h0, 32'h0, 1'b0);
        check_eq("c11_req", {31'b0, imem_req}, 32'h1);
        check_eq("c11_addr", imem_addr, 32'h40);
        mem_auto();
        tick();
        check_eq("c12_valid", {31'b0, inst_valid}, 32'h0);
        mem_auto();
        tick();
        check_out("c13", 32'hA5A5_0040, 32'h44, 1'b1);
        check_eq("c13_addr", imem_addr, 32'h48);
        imem_ack = 1'b0;

        // Branch while waiting: stale response must be dropped.
        tick();
        check_eq("c14_addr", imem_addr, 32'h48);
        br_taken = 1'b1;
        br_addr  = 32'h80;
        tick();
        br_taken = 1'b0;
        check_eq("c15_req", {31'b0, imem_req}, 32'h1);
        check_eq("c15_addr", imem_addr, 32'h48);
        check_eq("c15_valid", {31'b0, inst_valid}, 32'h0);
        tick();
        check_eq("c16_addr", imem_addr, 32'h48);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        check_eq("c17_addr", imem_addr, 32'h80);
        check_eq("c17_valid", {31'b0, inst_valid}, 32'h0);
        mem_auto();
        tick();
        check_out("c18", 32'h0, 32'h0, 1'b0);
        mem_auto();
        tick();
        check_out("c19", 32'hA5A5_0080, 32'h84, 1'b1);
        mem_auto();
        br_taken = 1'b1;
        freeze   = 1'b1;
        br_addr  = 32'h100;

        // Branch wins over freeze.
        tick();
        br_taken = 1'b0;
        freeze   = 1'b0;
        check_out("c20", 32'h0, 32'h0, 1'b0);
        check_eq("c20_addr", imem_addr, 32'h100);
        mem_auto();
        tick();
        mem_auto();
        tick();
        check_out("c22", 32'hA5A5_0100, 32'h104, 1'b1);
        check_eq("c22_addr", imem_addr, 32'h108);
        imem_ack = 1'b0;

        // Asynchronous reset during a pending request.
        tick();
        check_out("c23", 32'hA5A5_0104, 32'h108, 1'b1);
        check_eq("c23_req", {31'b0, imem_req}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_req", {31'b0, imem_req}, 32'h0);
        check_eq("arst_addr", imem_addr, 32'h0);
        check_out("arst", 32'h0, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("post_req", {31'b0, imem_req}, 32'h1);
        check_eq("post_addr", imem_addr, 32'h0);
        mem_auto();
        tick();
        mem_auto();
        tick();
        check_out("post", 32'hA5A5_0000, 32'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
